// File: rtl/fir_pkg.sv
// Shared FIR filter package: coefficient-loader FSM states, default filter
// dimensions and a counter-width helper used across filter blocks.
package fir_pkg;

    localparam int unsigned NR_STAGES_DEF = 32;
    localparam int unsigned DWIDTH_DEF    = 16;
    localparam int unsigned CWIDTH_DEF    = NR_STAGES_DEF * DWIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        FETCH,
        SHIFT,
        ACKLO,
        DONE
    } load_state_t;

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Fetches NR_STAGES coefficient words over a four-phase port and serialises
// them LSB first into the FIR wrapper, blocking samples while coefficients change.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int unsigned NR_STAGES = NR_STAGES_DEF,
    parameter int unsigned DWIDTH    = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    output logic              busy,
    output logic              coef_valid,
    output logic              load_done,
    output logic              coef_req,
    input  logic              coef_ack,
    input  logic [0:DWIDTH-1] coef_data,
    output logic              h,
    output logic              h_enabled,
    input  logic              filt_req_in,
    output logic              src_req_in,
    input  logic              src_ack_in
);

    localparam int unsigned BW = clog2w(DWIDTH);
    localparam int unsigned WW = clog2w(NR_STAGES + 1);

    load_state_t       state;
    load_state_t       next_state;
    logic [BW-1:0]     bit_cnt;
    logic [WW-1:0]     word_cnt;
    logic [0:DWIDTH-1] shreg;
    logic              open;
    logic              last_bit;
    logic              more_words;

    // Next-state logic; word_cnt counts words already captured this load.
    always_comb begin
        next_state = state;
        last_bit   = (bit_cnt == BW'(DWIDTH - 1));
        more_words = (word_cnt < WW'(NR_STAGES));
        case (state)
            IDLE: begin
                if (load_start) next_state = QUIESCE;
            end
            QUIESCE: begin
                if (!filt_req_in && !src_ack_in) next_state = FETCH;
            end
            FETCH: begin
                if (coef_ack) next_state = SHIFT;
            end
            SHIFT: begin
                if (last_bit) begin
                    if (coef_ack)        next_state = ACKLO;
                    else if (more_words) next_state = FETCH;
                    else                 next_state = DONE;
                end
            end
            ACKLO: begin
                if (!coef_ack) next_state = more_words ? FETCH : DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shreg      <= '0;
            open       <= 1'b0;
            coef_valid <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            coef_req   <= 1'b0;
            h_enabled  <= 1'b0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != IDLE);
            coef_req  <= (next_state == FETCH);
            h_enabled <= (next_state == SHIFT);
            load_done <= (state == DONE);

            if (state == QUIESCE && next_state == FETCH) begin
                open       <= 1'b0;
                coef_valid <= 1'b0;
                word_cnt   <= '0;
            end

            // Zero fill drives h low once the word has been fully shifted out.
            if (state == FETCH && coef_ack) begin
                shreg    <= coef_data;
                bit_cnt  <= '0;
                word_cnt <= word_cnt + WW'(1);
            end else if (state == SHIFT) begin
                shreg   <= {1'b0, shreg[0:DWIDTH-2]};
                bit_cnt <= bit_cnt + BW'(1);
            end

            if (state == DONE) begin
                coef_valid <= 1'b1;
                open       <= 1'b1;
            end
        end
    end

    assign h          = shreg[DWIDTH-1];
    assign src_req_in = filt_req_in & open;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with NR_STAGES=4, DWIDTH=8: a handshaking
// coefficient source and a shift-register model of the wrapper's h_in.
module tb_fir_coef_loader;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = NS * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          busy;
    logic          coef_valid;
    logic          load_done;
    logic          coef_req;
    logic          coef_ack = 1'b0;
    logic [0:DW-1] coef_data = '0;
    logic          h;
    logic          h_enabled;
    logic          filt_req_in = 1'b0;
    logic          src_req_in;
    logic          src_ack_in = 1'b0;

    fir_coef_loader #(.NR_STAGES(NS), .DWIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .busy        (busy),
        .coef_valid  (coef_valid),
        .load_done   (load_done),
        .coef_req    (coef_req),
        .coef_ack    (coef_ack),
        .coef_data   (coef_data),
        .h           (h),
        .h_enabled   (h_enabled),
        .filt_req_in (filt_req_in),
        .src_req_in  (src_req_in),
        .src_ack_in  (src_ack_in)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Wrapper model and event counters.
    logic [0:CW-1] img = '0;
    int            hen_total = 0;
    int            done_total = 0;

    always @(posedge clk) begin
        if (h_enabled) img <= {h, img[0:CW-2]};
        hen_total  <= hen_total + int'(h_enabled);
        done_total <= done_total + int'(load_done);
    end

    // Coefficient source: ack one cycle after req, drop ack src_hold cycles late.
    logic [7:0] words [NS];
    int         src_cnt  = 0;
    int         src_base = 0;
    int         src_hold = 0;
    int         hold_left = 0;

    initial begin
        words[0] = 8'h04;
        words[1] = 8'h03;
        words[2] = 8'h02;
        words[3] = 8'h01;
        forever begin
            @(posedge clk);
            if (coef_req && !coef_ack) begin
                #1;
                coef_data = words[(src_cnt - src_base) % NS];
                coef_ack  = 1'b1;
                hold_left = src_hold;
                src_cnt   = src_cnt + 1;
            end else if (!coef_req && coef_ack) begin
                if (hold_left > 0) hold_left = hold_left - 1;
                else begin
                    #1;
                    coef_ack = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the load_start cycle until load_done is seen; -1 on timeout.
    task automatic wait_done(input int start, output int cycles);
        cycles = start;
        while (!load_done && cycles < 400) begin
            step();
            cycles = cycles + 1;
        end
        if (!load_done) cycles = -1;
    endtask

    task automatic do_load(output int cycles);
        src_base   = src_cnt;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wait_done(1, cycles);
    endtask

    typedef struct packed {
        logic filt;
        logic sack;
        logic exp_req;
        logic exp_cv;
        logic exp_busy;
    } vec_t;

    localparam logic [31:0] IMAGE = 32'h01020304;

    initial begin
        vec_t vecs [6];
        int   cyc;
        int   hen0;
        int   done0;
        int   bad;

        vecs[0] = '{filt: 1'b1, sack: 1'b0, exp_req: 1'b1, exp_cv: 1'b1, exp_busy: 1'b0};
        vecs[1] = '{filt: 1'b1, sack: 1'b1, exp_req: 1'b1, exp_cv: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{filt: 1'b0, sack: 1'b1, exp_req: 1'b0, exp_cv: 1'b1, exp_busy: 1'b0};
        vecs[3] = '{filt: 1'b0, sack: 1'b0, exp_req: 1'b0, exp_cv: 1'b1, exp_busy: 1'b0};
        vecs[4] = '{filt: 1'b1, sack: 1'b0, exp_req: 1'b1, exp_cv: 1'b1, exp_busy: 1'b0};
        vecs[5] = '{filt: 1'b0, sack: 1'b0, exp_req: 1'b0, exp_cv: 1'b1, exp_busy: 1'b0};

        // Reset state with a pending sample request.
        filt_req_in = 1'b1;
        repeat (3) step();
        chk("rst_busy",       32'(busy), 0);
        chk("rst_coef_valid", 32'(coef_valid), 0);
        chk("rst_load_done",  32'(load_done), 0);
        chk("rst_coef_req",   32'(coef_req), 0);
        chk("rst_h_enabled",  32'(h_enabled), 0);
        chk("rst_h",          32'(h), 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (src_req_in || coef_valid) bad = bad + 1;
        end
        chk("preload_blocked", 32'(bad), 0);
        filt_req_in = 1'b0;
        step();

        // Basic load with one-cycle acks.
        hen0 = hen_total; done0 = done_total;
        do_load(cyc);
        chk("load1_cycles", 32'(cyc), 43);
        chk("load1_hen",    32'(hen_total - hen0), CW);
        chk("load1_image",  32'(img), IMAGE);
        chk("load1_valid",  32'(coef_valid), 1);
        chk("load1_done_n", 32'(done_total + int'(load_done) - done0), 1);
        step();
        chk("load1_idle",   32'(busy), 0);
        chk("load1_pulse",  32'(load_done), 0);

        // Sample gating once coefficients are valid.
        for (int i = 0; i < 6; i++) begin
            filt_req_in = vecs[i].filt;
            src_ack_in  = vecs[i].sack;
            #1;
            chk($sformatf("gate%0d_req", i), 32'(src_req_in), 32'(vecs[i].exp_req));
            chk($sformatf("gate%0d_cv", i), 32'(coef_valid), 32'(vecs[i].exp_cv));
            chk($sformatf("gate%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            step();
        end

        // Ack held long past the last bit: ACKLO stretches each word by 6 cycles.
        src_hold = 12;
        hen0 = hen_total;
        do_load(cyc);
        chk("acklo_cycles", 32'(cyc), 67);
        chk("acklo_hen",    32'(hen_total - hen0), CW);
        chk("acklo_image",  32'(img), IMAGE);
        src_hold = 0;
        repeat (3) step();

        // load_start during an in-flight sample handshake.
        filt_req_in = 1'b1;
        step();
        src_ack_in = 1'b1;
        src_base   = src_cnt;
        hen0       = hen_total;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (coef_req || h_enabled || !src_req_in || !busy) bad = bad + 1;
            step();
        end
        chk("quiesce_hold", 32'(bad), 0);
        filt_req_in = 1'b0;
        #1;
        chk("quiesce_req_drop", 32'(src_req_in), 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (coef_req || h_enabled) bad = bad + 1;
        end
        chk("quiesce_ack_wait", 32'(bad), 0);
        src_ack_in = 1'b0;
        wait_done(0, cyc);
        chk("quiesce_timeout", 32'(cyc >= 0), 1);
        chk("quiesce_hen",     32'(hen_total - hen0), CW);
        chk("quiesce_image",   32'(img), IMAGE);
        repeat (3) step();

        // Reset after two words have been shifted.
        hen0 = hen_total;
        src_base   = src_cnt;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        cyc = 0;
        while ((hen_total - hen0) < 2 * DW && cyc < 200) begin
            step();
            cyc = cyc + 1;
        end
        chk("midrst_reach", 32'(cyc < 200), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy",  32'(busy), 0);
        chk("midrst_req",   32'(coef_req), 0);
        chk("midrst_hen",   32'(h_enabled), 0);
        chk("midrst_valid", 32'(coef_valid), 0);
        filt_req_in = 1'b1;
        #1;
        chk("midrst_blocked", 32'(src_req_in), 0);
        filt_req_in = 1'b0;
        repeat (4) step();
        hen0 = hen_total;
        do_load(cyc);
        chk("reload_cycles", 32'(cyc), 43);
        chk("reload_hen",    32'(hen_total - hen0), CW);
        chk("reload_image",  32'(img), IMAGE);
        chk("reload_valid",  32'(coef_valid), 1);
        repeat (3) step();

        // Extra load_start pulses while busy are ignored.
        done0 = done_total;
        src_base   = src_cnt;
        load_start = 1'b1;
        step();
        cyc = 1;
        while (!load_done && cyc < 400) begin
            load_start = (cyc == 1 || cyc == 10 || cyc == 25 || cyc == 42);
            step();
            cyc = cyc + 1;
        end
        load_start = 1'b0;
        chk("ignore_cycles", 32'(cyc), 43);
        chk("ignore_image",  32'(img), IMAGE);
        repeat (6) step();
        chk("ignore_done_n", 32'(done_total - done0), 1);
        chk("ignore_idle",   32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
